// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and access decoder for dmem_lsu
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {INIT, RUN} dmem_state_t;

    typedef struct packed {
        logic [3:0] be;
        logic       err;
    } dmem_acc_t;

    // err covers illegal size codes (011/110/111) and misalignment
    function automatic dmem_acc_t dmem_decode(input logic [2:0] f3, input logic [1:0] off);
        dmem_acc_t a;
        a.be  = f3[1] ? 4'b1111 : f3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
        a.err = (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (f3[0] && off[0]) ||
                (f3[1] && off != 2'b00);
        return a;
    endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port word array with byte write enables and combinational read
module dmem_bank #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable RV32 data memory with LSU semantics and post-reset init sweep
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int IW = ADDR_WIDTH - 2;

    dmem_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    dmem_acc_t   dec;
    logic        acc, err;
    logic [3:0]  bank_we;
    logic [IW-1:0] bank_addr;
    logic [31:0] bank_wdata, bank_rdata, st_data, sh, ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == INIT) begin
            idx_d = idx_q + 1'b1;
            if (&idx_q) state_d = RUN;
        end
    end

    assign dec = dmem_decode(req_funct3, req_addr[1:0]);
    assign acc = req_valid && state_q == RUN;
    // unsigned codes are load-only, so a store using them is illegal
    assign err = dec.err || (req_we && req_funct3[2]);

    // replicate store data across lanes; byte enables pick the live lanes
    assign st_data = req_funct3[1] ? req_wdata :
                     req_funct3[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};

    always_comb begin
        bank_we    = (acc && req_we && !err) ? dec.be : 4'b0000;
        bank_addr  = req_addr[ADDR_WIDTH-1:2];
        bank_wdata = st_data;
        if (state_q == INIT) begin
            bank_we    = 4'b1111;
            bank_addr  = idx_q;
            bank_wdata = INIT_VALUE;
        end
    end

    dmem_bank #(.AW(IW)) u_bank (
        .clk    (clk),
        .we_i   (bank_we),
        .addr_i (bank_addr),
        .wdata_i(bank_wdata),
        .rdata_o(bank_rdata)
    );

    assign sh = bank_rdata >> {req_addr[1:0], 3'b000};
    assign ld = req_funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                req_funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                req_funct3 == F3_BU ? {24'h0, sh[7:0]} :
                req_funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;

    always_comb begin
        rsp_valid_d = acc;
        rsp_err_d   = acc && err;
        rsp_rdata_d = (acc && !req_we && !err) ? ld : 32'h0;
    end

    assign req_ready = state_q == RUN;
    assign init_done = state_q == RUN;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
